// File: rtl/regbank_param.sv
`default_nettype none
// ============================================================================
//  Module   : regbank_param
//  Purpose  : Parametrised register bank with two registered read ports, one
//             write port, optional hardwired-zero x0, a post-reset clear
//             sweep and a read-valid flag. Optional macro: REGBANK_BYPASS_EN
//             (write-first forwarding on same-address read/write).
//  Revision : 1.0 - initial release
// ============================================================================
module regbank_param #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int DEPTH     = 32,
    parameter bit ZERO_REG0 = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CSBar,
    input  logic              rdEn,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] regSelSrc0,
    input  logic [ADDR_W-1:0] regSelSrc1,
    input  logic [ADDR_W-1:0] regSelDst,
    input  logic [DATA_W-1:0] regDst,
    output logic [DATA_W-1:0] regSrc0,
    output logic [DATA_W-1:0] regSrc1,
    output logic              rdValid,
    output logic              ready
);

    localparam int                 c_IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]    c_DEPTH   = (ADDR_W + 1)'(DEPTH);
    localparam logic [c_IDX_W-1:0] c_LAST    = c_IDX_W'(DEPTH - 1);
    localparam logic [0:0]         c_ST_INIT = 1'b0;
    localparam logic [0:0]         c_ST_RUN  = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_stateNext;
    logic [c_IDX_W-1:0] r_clrCnt;
    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [DATA_W-1:0]  r_src0;
    logic [DATA_W-1:0]  r_src1;
    logic               r_rdValid;

    logic               w_run;
    logic               w_rdAcc;
    logic               w_wrAcc;
    logic [c_IDX_W-1:0] w_dstIdx;
    logic [ADDR_W-1:0]  w_rdSel  [2];
    logic [DATA_W-1:0]  w_rdData [2];

    // A selector is live when it names a real register that is not the
    // hardwired-zero x0; anything else reads 0 and swallows writes.
    function automatic logic addrOk(input logic [ADDR_W-1:0] sel);
        return ({1'b0, sel} < c_DEPTH) && !(ZERO_REG0 && (sel == '0));
    endfunction

    assign w_run    = (r_state == c_ST_RUN);
    assign w_rdAcc  = w_run && !CSBar && rdEn;
    assign w_wrAcc  = w_run && !CSBar && wrEn && addrOk(regSelDst);
    assign w_dstIdx = regSelDst[c_IDX_W-1:0];

    assign w_rdSel[0] = regSelSrc0;
    assign w_rdSel[1] = regSelSrc1;

    for (genvar p = 0; p < 2; p++) begin : g_rdPort
        logic [c_IDX_W-1:0] w_idx;
        logic               w_ok;
        logic               w_fwd;

        assign w_idx = w_rdSel[p][c_IDX_W-1:0];
        assign w_ok  = addrOk(w_rdSel[p]);
`ifdef REGBANK_BYPASS_EN
        // Only accepted writes forward, so suppressed targets never leak.
        assign w_fwd = w_wrAcc && (w_rdSel[p] == regSelDst);
`else
        assign w_fwd = 1'b0;
`endif
        assign w_rdData[p] = !w_ok ? '0 : (w_fwd ? regDst : r_mem[w_idx]);
    end

    always_comb begin
        w_stateNext = r_state;
        if ((r_state == c_ST_INIT) && (r_clrCnt == c_LAST)) begin
            w_stateNext = c_ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_INIT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clrCnt  <= '0;
            r_src0    <= '0;
            r_src1    <= '0;
            r_rdValid <= 1'b0;
        end else begin
            if (!w_run) begin
                r_clrCnt <= r_clrCnt + 1'b1;
            end
            r_rdValid <= w_rdAcc;
            if (w_rdAcc) begin
                r_src0 <= w_rdData[0];
                r_src1 <= w_rdData[1];
            end
        end
    end

    // Storage has no reset; the INIT sweep zeroes it one entry per clock.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!w_run) begin
                r_mem[r_clrCnt] <= '0;
            end else if (w_wrAcc) begin
                r_mem[w_dstIdx] <= regDst;
            end
        end
    end

    assign regSrc0 = r_src0;
    assign regSrc1 = r_src1;
    assign rdValid = r_rdValid;
    assign ready   = w_run;

endmodule
`default_nettype wire

// File: doc/regbank_param.md
Name: regbank_param

Overview:
- Parametrised register bank for the RISC-V datapath, generalising the fixed 32 x 32 bank.
- Two registered read ports (Src0/Src1) feed the ALU; one write port (Dst) takes the ALU result.
- Separate read and write enables replace the single RD/WR strobe; adds hardwired-zero x0, a post-reset clear sweep, and a read-valid flag.

Parameters:
- DATA_W, 32, width of each register and of the data ports
- ADDR_W, 5, width of the register selectors
- DEPTH, 32, number of registers; must satisfy 2 <= DEPTH <= 2**ADDR_W
- ZERO_REG0, 1, 1 = register 0 reads as zero and ignores writes; 0 = register 0 is an ordinary register

Ports:
- clk  in  1  positive-edge clock
- rst  in  1  asynchronous reset, active-high
- CSBar  in  1  bank chip select, active-low; gates all accesses
- rdEn  in  1  read request for both read ports
- wrEn  in  1  write request
- regSelSrc0  in  ADDR_W  read port 0 selector
- regSelSrc1  in  ADDR_W  read port 1 selector
- regSelDst  in  ADDR_W  write selector
- regDst  in  DATA_W  write data
- regSrc0  out  DATA_W  read port 0 data, registered
- regSrc1  out  DATA_W  read port 1 data, registered
- rdValid  out  1  regSrc0/regSrc1 hold data from a read accepted on the previous edge
- ready  out  1  clear sweep finished; bank accepts accesses

Behaviour:
- Reset: one clk; rst is asynchronous and active-high. While rst=1: state=INIT, clrCnt=0, regSrc0=0, regSrc1=0, rdValid=0, ready=0. The storage array has no async reset.
- FSM INIT:
  - Each posedge writes 0 to mem[clrCnt] and increments clrCnt.
  - On the edge that clears entry DEPTH-1, state goes to RUN and ready goes to 1.
  - ready therefore rises on the DEPTH-th posedge after rst deasserts.
  - CSBar, rdEn and wrEn are ignored in INIT; rdValid stays 0.
- FSM RUN: stays in RUN until rst is asserted.
- Write (RUN only):
  - On posedge, if CSBar=0 and wrEn=1, then mem[regSelDst] <= regDst.
  - Write is suppressed if ZERO_REG0=1 and regSelDst=0, or if regSelDst >= DEPTH.
- Read (RUN only):
  - On posedge, if CSBar=0 and rdEn=1, then regSrcN <= mem[regSelSrcN] and rdValid <= 1.
  - Latency is 1 cycle from request edge to data.
  - Selector 0 with ZERO_REG0=1 returns 0; selector >= DEPTH returns 0.
- No read accepted on an edge: rdValid <= 0; regSrc0/regSrc1 hold their last value.
- Simultaneous read and write to the same address on one edge: behaviour is set by REGBANK_BYPASS_EN.
- Both read ports may select the same register; both return identical data.
- CSBar=1 overrides rdEn and wrEn: no state change except rdValid <= 0.
- Reset mid-operation:
  - A write coinciding with rst assertion is discarded.
  - On rst, outputs return to their reset values and the INIT sweep repeats, zeroing all contents.

Optional Feature:
- Macro: REGBANK_BYPASS_EN.
- Defined: a read and write to the same non-suppressed address on one edge returns the new regDst on the read port next cycle (write-first forwarding), independently per port.
- Undefined: the read returns the old stored value (read-first); the new value is visible from the following read.
- Suppressed writes (x0 with ZERO_REG0=1, or out-of-range address) are never forwarded in either build.

Test Plan:
- Reset/init: assert rst, release; DEPTH=32 -> ready=0 for 31 posedges, ready=1 at the 32nd; all 32 registers read back 32'h00000000.
- Write/read: write 32'hFAEAFAEA to reg 3, then read with Src0=3, Src1=3 -> one cycle later regSrc0=regSrc1=32'hFAEAFAEA, rdValid=1; next idle cycle -> rdValid=0, data held.
- x0: write 32'hDEADBEEF to reg 0 with ZERO_REG0=1 -> reading reg 0 returns 0. With ZERO_REG0=0 -> reading reg 0 returns 32'hDEADBEEF.
- Same-edge read and write: reg 5 holds 32'h11111111; write 32'h22222222 to reg 5 while reading Src0=5 -> regSrc0=32'h22222222 with REGBANK_BYPASS_EN defined, 32'h11111111 without; a following read returns 32'h22222222 in both builds.
- Gating:
  - CSBar=1 with wrEn=1 and rdEn=1 -> memory unchanged, rdValid=0.
  - Requests during INIT -> ignored; target register still 0 after ready.
- Mid-operation reset: write reg 7 = 32'hA5A5A5A5, assert rst asynchronously between edges -> regSrc0, regSrc1, rdValid and ready go to 0 immediately; after re-init, reg 7 reads 0.
